// File: rtl/video_timing.sv
// Raster timing generator: game-pixel position, look-ahead position, active-low syncs, blanking and frame strobes.
// Latency: every output is registered and describes the counter position held during the current tick.
// Backpressure: enable_i low freezes all counters and outputs; the one-tick strobes are forced low while frozen.
module video_timing #(
    parameter int H_VISIBLE   = 256,
    parameter int H_FRONT     = 32,
    parameter int H_SYNC      = 48,
    parameter int H_BACK      = 64,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int LINE_REPEAT = 2
) (
    input  logic       gpu_clk,
    input  logic       rst,
    input  logic       enable_i,
    output logic [8:0] current_x_o,
    output logic [8:0] current_y_o,
    output logic [8:0] next_x_o,
    output logic [8:0] next_y_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       visible_o,
    output logic       vblank_o,
    output logic       vblank_start_o,
    output logic       frame_start_o,
    output logic [7:0] frame_count_o
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    // Guarded so an illegal LINE_REPEAT still elaborates far enough to report its error.
    localparam int REP_W   = (LINE_REPEAT > 2) ? $clog2(LINE_REPEAT) : 1;
    localparam int ROWS    = (LINE_REPEAT > 0) ? (V_TOTAL + LINE_REPEAT - 1) / LINE_REPEAT : 1;

    // Horizontal thresholds carry one spare bit so a 512-tick line cannot overflow them.
    localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_STOP  = 10'(H_VISIBLE + H_FRONT + H_SYNC);

    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_STOP  = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic [REP_W-1:0] REP_LAST = REP_W'(LINE_REPEAT - 1);
    // The final game row may be short when V_TOTAL is not a multiple of LINE_REPEAT.
    localparam logic [8:0] ROW_LAST = 9'(ROWS - 1);
    localparam logic [8:0] NX_RST   = (H_LAST == 9'd0) ? 9'd0 : 9'd1;
    localparam logic [8:0] NY_RST   = (ROW_LAST == 9'd0) ? 9'd0 : 9'd1;

    // Parameter sanity: the fixed output widths bound the raster size.
    generate
        if (LINE_REPEAT < 2) begin : g_chk_repeat
            $error("video_timing: LINE_REPEAT must be at least 2");
        end
        if (H_TOTAL > 512) begin : g_chk_htotal
            $error("video_timing: H_TOTAL must not exceed 512");
        end
        if (LINE_REPEAT > V_TOTAL) begin : g_chk_vrep
            $error("video_timing: LINE_REPEAT must not exceed V_TOTAL");
        end
        if (V_TOTAL > 1024) begin : g_chk_vtotal
            $error("video_timing: V_TOTAL must not exceed 1024");
        end
    endgenerate

    // Raster position state
    logic [8:0]       r_h_count;
    logic [9:0]       r_v_count;
    logic [REP_W-1:0] r_rep;
    logic [8:0]       r_y_row;

    // Registered outputs that are not plain copies of the counters
    logic [8:0] r_next_x;
    logic [8:0] r_next_y;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_visible;
    logic       r_vblank;
    logic       r_vblank_start;
    logic       r_frame_start;
    logic [7:0] r_frame_count;

    // Position after the next advancing tick, and the outputs that describe it
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_rep_wrap;
    logic [8:0]       w_h_nxt;
    logic [9:0]       w_v_nxt;
    logic [REP_W-1:0] w_rep_nxt;
    logic [8:0]       w_y_nxt;
    logic             w_frame_end;
    logic [8:0]       w_next_x_nxt;
    logic [8:0]       w_next_y_nxt;
    logic             w_hsync_nxt;
    logic             w_vsync_nxt;
    logic             w_vblank_nxt;
    logic             w_visible_nxt;
    logic             w_vblank_start_nxt;

    assign w_h_wrap   = (r_h_count == H_LAST);
    assign w_v_wrap   = (r_v_count == V_LAST);
    assign w_rep_wrap = (r_rep == REP_LAST);

    // Counter step: h always moves, v/rep/row only on the line wrap, everything clears at frame end.
    always_comb begin
        w_h_nxt     = r_h_count + 9'd1;
        w_v_nxt     = r_v_count;
        w_rep_nxt   = r_rep;
        w_y_nxt     = r_y_row;
        w_frame_end = 1'b0;
        if (w_h_wrap) begin
            w_h_nxt = '0;
            if (w_v_wrap) begin
                w_v_nxt     = '0;
                w_rep_nxt   = '0;
                w_y_nxt     = '0;
                w_frame_end = 1'b1;
            end else begin
                w_v_nxt = r_v_count + 10'd1;
                if (w_rep_wrap) begin
                    w_rep_nxt = '0;
                    w_y_nxt   = r_y_row + 9'd1;
                end else begin
                    w_rep_nxt = r_rep + REP_W'(1);
                end
            end
        end
    end

    // Decode the upcoming position so the outputs can be registered alongside the counters.
    always_comb begin
        w_next_x_nxt       = (w_h_nxt == H_LAST) ? 9'd0 : w_h_nxt + 9'd1;
        w_next_y_nxt       = (w_y_nxt == ROW_LAST) ? 9'd0 : w_y_nxt + 9'd1;
        w_hsync_nxt        = !(({1'b0, w_h_nxt} >= HS_START) && ({1'b0, w_h_nxt} < HS_STOP));
        w_vsync_nxt        = !(({1'b0, w_v_nxt} >= VS_START) && ({1'b0, w_v_nxt} < VS_STOP));
        w_vblank_nxt       = ({1'b0, w_v_nxt} >= V_VIS);
        w_visible_nxt      = ({1'b0, w_h_nxt} < H_VIS) && !w_vblank_nxt;
        // Entering h=0 of the first blanked line happens exactly once per frame.
        w_vblank_start_nxt = w_h_wrap && ({1'b0, w_v_nxt} == V_VIS);
    end

    // Advance the raster counters on enabled ticks; hold them otherwise.
    always_ff @(posedge gpu_clk or negedge rst) begin
        if (!rst) begin
            r_h_count <= '0;
            r_v_count <= '0;
            r_rep     <= '0;
            r_y_row   <= '0;
        end else if (enable_i) begin
            r_h_count <= w_h_nxt;
            r_v_count <= w_v_nxt;
            r_rep     <= w_rep_nxt;
            r_y_row   <= w_y_nxt;
        end
    end

    // Register the outputs for the new position; while stalled hold levels and drop the strobes.
    always_ff @(posedge gpu_clk or negedge rst) begin
        if (!rst) begin
            r_next_x       <= NX_RST;
            r_next_y       <= NY_RST;
            r_hsync        <= 1'b1;
            r_vsync        <= 1'b1;
            r_visible      <= 1'b1;
            r_vblank       <= 1'b0;
            r_vblank_start <= 1'b0;
            r_frame_start  <= 1'b0;
            r_frame_count  <= '0;
        end else if (enable_i) begin
            r_next_x       <= w_next_x_nxt;
            r_next_y       <= w_next_y_nxt;
            r_hsync        <= w_hsync_nxt;
            r_vsync        <= w_vsync_nxt;
            r_visible      <= w_visible_nxt;
            r_vblank       <= w_vblank_nxt;
            r_vblank_start <= w_vblank_start_nxt;
            r_frame_start  <= w_frame_end;
            if (w_frame_end) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end else begin
            r_vblank_start <= 1'b0;
            r_frame_start  <= 1'b0;
        end
    end

    assign current_x_o    = r_h_count;
    assign current_y_o    = r_y_row;
    assign next_x_o       = r_next_x;
    assign next_y_o       = r_next_y;
    assign hsync_o        = r_hsync;
    assign vsync_o        = r_vsync;
    assign visible_o      = r_visible;
    assign vblank_o       = r_vblank;
    assign vblank_start_o = r_vblank_start;
    assign frame_start_o  = r_frame_start;
    assign frame_count_o  = r_frame_count;

endmodule

// File: tb/tb_video_timing.sv
// Directed bench for video_timing: default raster for line-level timing, a miniature raster
// (8 ticks x 11 lines) for frame-level behaviour, and LINE_REPEAT=3 variants for row folding.
`timescale 1ns/1ps
module tb_video_timing;

    logic gpu_clk = 1'b0;
    logic rst     = 1'b0;
    logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0, en_d = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [8:0] a_cx, a_cy, a_nx, a_ny; logic a_hs, a_vs, a_vis, a_vb, a_vbs, a_fs; logic [7:0] a_fc;
    logic [8:0] b_cx, b_cy, b_nx, b_ny; logic b_hs, b_vs, b_vis, b_vb, b_vbs, b_fs; logic [7:0] b_fc;
    logic [8:0] c_cx, c_cy, c_nx, c_ny; logic c_hs, c_vs, c_vis, c_vb, c_vbs, c_fs; logic [7:0] c_fc;
    logic [8:0] d_cx, d_cy, d_nx, d_ny; logic d_hs, d_vs, d_vis, d_vb, d_vbs, d_fs; logic [7:0] d_fc;

    always #5 gpu_clk = ~gpu_clk;

    // A: default raster, LINE_REPEAT=2
    video_timing u_a (
        .gpu_clk(gpu_clk), .rst(rst), .enable_i(en_a),
        .current_x_o(a_cx), .current_y_o(a_cy), .next_x_o(a_nx), .next_y_o(a_ny),
        .hsync_o(a_hs), .vsync_o(a_vs), .visible_o(a_vis), .vblank_o(a_vb),
        .vblank_start_o(a_vbs), .frame_start_o(a_fs), .frame_count_o(a_fc));

    // B: miniature raster H_TOTAL=8 (hsync h=5..6), V_TOTAL=11 (vblank v>=6, vsync v=8..9), rows 0..5
    video_timing #(.H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                   .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(1), .LINE_REPEAT(2)) u_b (
        .gpu_clk(gpu_clk), .rst(rst), .enable_i(en_b),
        .current_x_o(b_cx), .current_y_o(b_cy), .next_x_o(b_nx), .next_y_o(b_ny),
        .hsync_o(b_hs), .vsync_o(b_vs), .visible_o(b_vis), .vblank_o(b_vb),
        .vblank_start_o(b_vbs), .frame_start_o(b_fs), .frame_count_o(b_fc));

    // C: default raster, LINE_REPEAT=3
    video_timing #(.LINE_REPEAT(3)) u_c (
        .gpu_clk(gpu_clk), .rst(rst), .enable_i(en_c),
        .current_x_o(c_cx), .current_y_o(c_cy), .next_x_o(c_nx), .next_y_o(c_ny),
        .hsync_o(c_hs), .vsync_o(c_vs), .visible_o(c_vis), .vblank_o(c_vb),
        .vblank_start_o(c_vbs), .frame_start_o(c_fs), .frame_count_o(c_fc));

    // D: miniature raster with LINE_REPEAT=3, rows 0..3 (last row two lines)
    video_timing #(.H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                   .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(1), .LINE_REPEAT(3)) u_d (
        .gpu_clk(gpu_clk), .rst(rst), .enable_i(en_d),
        .current_x_o(d_cx), .current_y_o(d_cy), .next_x_o(d_nx), .next_y_o(d_ny),
        .hsync_o(d_hs), .vsync_o(d_vs), .visible_o(d_vis), .vblank_o(d_vb),
        .vblank_start_o(d_vbs), .frame_start_o(d_fs), .frame_count_o(d_fc));

    // Returns on a falling edge with reset just released and every instance stalled.
    task automatic do_reset();
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; en_d = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge gpu_clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [49:0] got, exp;
        exp = {9'd0, 9'd0, 9'd1, 9'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; en_d = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge gpu_clk);
        got = {a_cx, a_cy, a_nx, a_ny, a_hs, a_vs, a_vis, a_vb, a_vbs, a_fs, a_fc};
        checks++; if (got !== exp) begin errors++; $display("FAIL reset_state_a: got %h want %h", got, exp); end
        got = {d_cx, d_cy, d_nx, d_ny, d_hs, d_vs, d_vis, d_vb, d_vbs, d_fs, d_fc};
        checks++; if (got !== exp) begin errors++; $display("FAIL reset_state_d: got %h want %h", got, exp); end
        // A runs 150 ticks; B joins late and runs 69 ticks -> h=5, v=8 (inside both sync pulses)
        rst = 1'b1; en_a = 1'b1;
        for (int k = 0; k < 150; k++) begin
            en_b = (k >= 81);
            @(negedge gpu_clk);
        end
        checks++; if (a_cx !== 9'd150) begin errors++; $display("FAIL pre_reset_a_x: got %0d want 150", a_cx); end
        checks++; if (b_cx !== 9'd5) begin errors++; $display("FAIL pre_reset_b_x: got %0d want 5", b_cx); end
        checks++; if (b_cy !== 9'd4) begin errors++; $display("FAIL pre_reset_b_y: got %0d want 4", b_cy); end
        checks++; if (b_hs !== 1'b0) begin errors++; $display("FAIL pre_reset_b_hs: got %b want 0", b_hs); end
        checks++; if (b_vs !== 1'b0) begin errors++; $display("FAIL pre_reset_b_vs: got %b want 0", b_vs); end
        // Asynchronous assertion mid-frame
        rst = 1'b0;
        #1;
        checks++; if (a_cx !== 9'd0) begin errors++; $display("FAIL async_reset_a_x: got %0d want 0", a_cx); end
        checks++; if ({b_cx, b_cy} !== 18'd0) begin errors++; $display("FAIL async_reset_b_xy: got %0d,%0d want 0,0", b_cx, b_cy); end
        checks++; if ({b_hs, b_vs} !== 2'b11) begin errors++; $display("FAIL async_reset_b_sync: got %b want 11", {b_hs, b_vs}); end
        checks++; if (b_fc !== 8'd0) begin errors++; $display("FAIL async_reset_b_fc: got %0d want 0", b_fc); end
        repeat (2) @(negedge gpu_clk);
        rst = 1'b1; en_a = 1'b1; en_b = 1'b1;
        checks++; if ({a_fs, b_fs} !== 2'b00) begin errors++; $display("FAIL release_no_fs: got %b want 00", {a_fs, b_fs}); end
        @(negedge gpu_clk);
        checks++; if ({a_cx, b_cx} !== {9'd1, 9'd1}) begin errors++; $display("FAIL release_x: got %0d,%0d want 1,1", a_cx, b_cx); end
        checks++; if ({b_cy, b_fs, b_fc} !== 18'd0) begin errors++; $display("FAIL release_b_state: got y=%0d fs=%b fc=%0d want 0,0,0", b_cy, b_fs, b_fc); end
        en_a = 1'b0; en_b = 1'b0;
    endtask

    task automatic test_line();
        int hs_low, hs_first, vis_cnt;
        logic ehs;
        hs_low = 0; hs_first = -1; vis_cnt = 0;
        do_reset();
        en_a = 1'b1;
        for (int k = 0; k < 400; k++) begin
            ehs = !(k >= 288 && k < 336);
            checks++; if (a_cx !== 9'(k)) begin errors++; $display("FAIL line_x k=%0d: got %0d want %0d", k, a_cx, k); end
            checks++; if (a_nx !== ((k == 399) ? 9'd0 : 9'(k + 1))) begin errors++; $display("FAIL line_next_x k=%0d: got %0d", k, a_nx); end
            checks++; if (a_hs !== ehs) begin errors++; $display("FAIL line_hsync k=%0d: got %b want %b", k, a_hs, ehs); end
            if (a_hs === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = k;
            end
            if (a_vis === 1'b1) vis_cnt++;
            @(negedge gpu_clk);
        end
        checks++; if (hs_low != 48) begin errors++; $display("FAIL hsync_width: got %0d want 48", hs_low); end
        checks++; if (hs_first != 288) begin errors++; $display("FAIL hsync_start: got %0d want 288", hs_first); end
        checks++; if (vis_cnt != 256) begin errors++; $display("FAIL visible_width: got %0d want 256", vis_cnt); end
        // Second screen line of row 0
        checks++; if ({a_cx, a_cy, a_ny} !== {9'd0, 9'd0, 9'd1}) begin errors++; $display("FAIL line1_pos: got x=%0d y=%0d ny=%0d want 0,0,1", a_cx, a_cy, a_ny); end
        repeat (400) @(negedge gpu_clk);
        checks++; if ({a_cy, a_ny, a_vs} !== {9'd1, 9'd2, 1'b1}) begin errors++; $display("FAIL line2_row: got y=%0d ny=%0d vs=%b want 1,2,1", a_cy, a_ny, a_vs); end
        en_a = 1'b0;
    endtask

    task automatic test_frame();
        int rows[6];
        int h, v, ey, vs_low, vs_first, vbs_cnt;
        vs_low = 0; vs_first = -1; vbs_cnt = 0;
        for (int r = 0; r < 6; r++) rows[r] = 0;
        do_reset();
        en_b = 1'b1;
        for (int k = 0; k < 88; k++) begin
            h = k % 8; v = k / 8; ey = v / 2;
            checks++; if (b_cx !== 9'(h)) begin errors++; $display("FAIL frame_x k=%0d: got %0d want %0d", k, b_cx, h); end
            checks++; if (b_cy !== 9'(ey)) begin errors++; $display("FAIL frame_y k=%0d: got %0d want %0d", k, b_cy, ey); end
            checks++; if (b_ny !== ((ey == 5) ? 9'd0 : 9'(ey + 1))) begin errors++; $display("FAIL frame_next_y k=%0d: got %0d", k, b_ny); end
            checks++; if (b_vs !== !(v >= 8 && v < 10)) begin errors++; $display("FAIL frame_vsync k=%0d: got %b", k, b_vs); end
            checks++; if (b_vb !== (v >= 6)) begin errors++; $display("FAIL frame_vblank k=%0d: got %b", k, b_vb); end
            checks++; if (b_vis !== (h < 4 && v < 6)) begin errors++; $display("FAIL frame_visible k=%0d: got %b", k, b_vis); end
            checks++; if (b_vbs !== (v == 6 && h == 0)) begin errors++; $display("FAIL frame_vblank_start k=%0d: got %b", k, b_vbs); end
            checks++; if (b_fs !== 1'b0) begin errors++; $display("FAIL frame_start_early k=%0d: got %b want 0", k, b_fs); end
            if (b_cy < 9'd6) rows[b_cy]++;
            if (b_vs === 1'b0) begin
                vs_low++;
                if (vs_first < 0) vs_first = k;
            end
            if (b_vbs === 1'b1) vbs_cnt++;
            @(negedge gpu_clk);
        end
        for (int r = 0; r < 6; r++) begin
            checks++; if (rows[r] != ((r < 5) ? 16 : 8)) begin errors++; $display("FAIL row_len r=%0d: got %0d want %0d", r, rows[r], (r < 5) ? 16 : 8); end
        end
        checks++; if (vs_low != 16 || vs_first != 64) begin errors++; $display("FAIL vsync_window: got len=%0d start=%0d want 16,64", vs_low, vs_first); end
        checks++; if (vbs_cnt != 1) begin errors++; $display("FAIL vblank_start_count: got %0d want 1", vbs_cnt); end
        checks++; if ({b_fs, b_fc, b_cx, b_cy, b_ny} !== {1'b1, 8'd1, 9'd0, 9'd0, 9'd1}) begin
            errors++; $display("FAIL frame_wrap: got fs=%b fc=%0d x=%0d y=%0d ny=%0d want 1,1,0,0,1", b_fs, b_fc, b_cx, b_cy, b_ny);
        end
        @(negedge gpu_clk);
        checks++; if (b_fs !== 1'b0) begin errors++; $display("FAIL frame_start_single: got %b want 0", b_fs); end
        en_b = 1'b0;
    endtask

    task automatic test_frame_count();
        int fs_cnt, vbs_cnt;
        fs_cnt = 0; vbs_cnt = 0;
        do_reset();
        en_b = 1'b1;
        for (int k = 0; k < 88 * 256; k++) begin
            if (k == 88 * 255) begin
                checks++; if ({b_fc, b_fs} !== {8'd255, 1'b1}) begin errors++; $display("FAIL frame_count_255: got fc=%0d fs=%b want 255,1", b_fc, b_fs); end
            end
            if (b_fs === 1'b1) fs_cnt++;
            if (b_vbs === 1'b1) vbs_cnt++;
            @(negedge gpu_clk);
        end
        checks++; if ({b_fc, b_fs} !== {8'd0, 1'b1}) begin errors++; $display("FAIL frame_count_wrap: got fc=%0d fs=%b want 0,1", b_fc, b_fs); end
        checks++; if (fs_cnt != 255) begin errors++; $display("FAIL frame_start_pulses: got %0d want 255", fs_cnt); end
        checks++; if (vbs_cnt != 256) begin errors++; $display("FAIL vblank_start_pulses: got %0d want 256", vbs_cnt); end
        en_b = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        en_a = 1'b1;
        repeat (287) @(negedge gpu_clk);
        checks++; if ({a_cx, a_hs} !== {9'd287, 1'b1}) begin errors++; $display("FAIL stall_entry: got x=%0d hs=%b want 287,1", a_cx, a_hs); end
        en_a = 1'b0;
        for (int i = 0; i < 37; i++) begin
            @(negedge gpu_clk);
            checks++; if ({a_cx, a_nx, a_hs, a_vis} !== {9'd287, 9'd288, 1'b1, 1'b0}) begin
                errors++; $display("FAIL stall_hold i=%0d: got x=%0d nx=%0d hs=%b vis=%b", i, a_cx, a_nx, a_hs, a_vis);
            end
            checks++; if ({a_vbs, a_fs} !== 2'b00) begin errors++; $display("FAIL stall_pulses i=%0d: got %b want 00", i, {a_vbs, a_fs}); end
        end
        en_a = 1'b1;
        @(negedge gpu_clk);
        checks++; if ({a_cx, a_hs} !== {9'd288, 1'b0}) begin errors++; $display("FAIL stall_resume: got x=%0d hs=%b want 288,0", a_cx, a_hs); end
        en_a = 1'b0;
        // Stall while a strobe is high on the miniature raster
        do_reset();
        en_b = 1'b1;
        repeat (48) @(negedge gpu_clk);
        checks++; if ({b_vbs, b_vb} !== 2'b11) begin errors++; $display("FAIL vbs_before_stall: got %b want 11", {b_vbs, b_vb}); end
        en_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge gpu_clk);
            checks++; if ({b_vbs, b_vb, b_cx, b_cy} !== {1'b0, 1'b1, 9'd0, 9'd3}) begin
                errors++; $display("FAIL vbs_stall i=%0d: got vbs=%b vb=%b x=%0d y=%0d", i, b_vbs, b_vb, b_cx, b_cy);
            end
        end
        en_b = 1'b1;
        @(negedge gpu_clk);
        checks++; if ({b_cx, b_vbs} !== {9'd1, 1'b0}) begin errors++; $display("FAIL vbs_resume: got x=%0d vbs=%b want 1,0", b_cx, b_vbs); end
        repeat (39) @(negedge gpu_clk);
        checks++; if ({b_fs, b_fc} !== {1'b1, 8'd1}) begin errors++; $display("FAIL fs_before_stall: got fs=%b fc=%0d want 1,1", b_fs, b_fc); end
        en_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge gpu_clk);
            checks++; if ({b_fs, b_fc, b_cx} !== {1'b0, 8'd1, 9'd0}) begin
                errors++; $display("FAIL fs_stall i=%0d: got fs=%b fc=%0d x=%0d", i, b_fs, b_fc, b_cx);
            end
        end
        en_b = 1'b1;
        @(negedge gpu_clk);
        checks++; if ({b_fs, b_fc, b_cx} !== {1'b0, 8'd1, 9'd1}) begin errors++; $display("FAIL fs_resume: got fs=%b fc=%0d x=%0d", b_fs, b_fc, b_cx); end
        en_b = 1'b0;
    endtask

    task automatic test_repeat3();
        int rows[4];
        int ey, maxy;
        maxy = 0;
        for (int r = 0; r < 4; r++) rows[r] = 0;
        do_reset();
        en_c = 1'b1;
        for (int k = 0; k < 3600; k++) begin
            checks++; if ({c_cy, c_ny} !== {9'(k / 1200), 9'(k / 1200 + 1)}) begin
                errors++; $display("FAIL rep3_row k=%0d: got y=%0d ny=%0d want %0d,%0d", k, c_cy, c_ny, k / 1200, k / 1200 + 1);
            end
            @(negedge gpu_clk);
        end
        checks++; if ({c_cy, c_cx} !== {9'd3, 9'd0}) begin errors++; $display("FAIL rep3_row3: got y=%0d x=%0d want 3,0", c_cy, c_cx); end
        en_c = 1'b0;
        do_reset();
        en_d = 1'b1;
        for (int k = 0; k < 88; k++) begin
            ey = (k / 8) / 3;
            checks++; if (d_cy !== 9'(ey)) begin errors++; $display("FAIL rep3_mini_y k=%0d: got %0d want %0d", k, d_cy, ey); end
            checks++; if (d_ny !== ((ey == 3) ? 9'd0 : 9'(ey + 1))) begin errors++; $display("FAIL rep3_mini_ny k=%0d: got %0d", k, d_ny); end
            if (d_cy < 9'd4) rows[d_cy]++;
            if (int'(d_cy) > maxy) maxy = int'(d_cy);
            @(negedge gpu_clk);
        end
        checks++; if (maxy != 3) begin errors++; $display("FAIL rep3_max_row: got %0d want 3", maxy); end
        for (int r = 0; r < 4; r++) begin
            checks++; if (rows[r] != ((r < 3) ? 24 : 16)) begin errors++; $display("FAIL rep3_row_len r=%0d: got %0d want %0d", r, rows[r], (r < 3) ? 24 : 16); end
        end
        checks++; if ({d_cy, d_fs, d_fc} !== {9'd0, 1'b1, 8'd1}) begin errors++; $display("FAIL rep3_wrap: got y=%0d fs=%b fc=%0d want 0,1,1", d_cy, d_fs, d_fc); end
        en_d = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_frame_count();
        test_stall();
        test_repeat3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_timing.md
Name: video_timing

Overview:
- Upstream stage of the GPU layer pipeline (foreground, background, mixer).
- Produces per-pixel raster position, look-ahead position, active-low sync pulses and blanking/frame strobes, all in game-pixel units.
- One gpu_clk tick = one game pixel. The screen line count is folded into game rows by LINE_REPEAT.
- Every consumer layer derives its prefetch window from current_x_o/next_y_o, and its scanline swap from hsync_o.

Parameters:
- H_VISIBLE, 256, visible game pixels per line
- H_FRONT, 32, front porch in gpu_clk ticks
- H_SYNC, 48, hsync pulse width in ticks
- H_BACK, 64, back porch in ticks (H_TOTAL = 400)
- V_VISIBLE, 480, visible screen lines
- V_FRONT, 10, vertical front porch in screen lines
- V_SYNC, 2, vsync width in screen lines
- V_BACK, 33, vertical back porch in screen lines (V_TOTAL = 525)
- LINE_REPEAT, 2, screen lines per game row; must be ≥2

Ports:
- gpu_clk  input  1  pixel clock
- rst  input  1  asynchronous, active-low reset
- enable_i  input  1  advance raster when high; freeze all state when low
- current_x_o  output  9  game x of the current tick, 0..H_TOTAL-1
- current_y_o  output  9  game row of the current screen line = v_count/LINE_REPEAT
- next_x_o  output  9  current_x_o value on the next advancing tick
- next_y_o  output  9  game row displayed after current_y_o
- hsync_o  output  1  active-low horizontal sync
- vsync_o  output  1  active-low vertical sync
- visible_o  output  1  high when h_count<H_VISIBLE and v_count<V_VISIBLE
- vblank_o  output  1  high when v_count≥V_VISIBLE
- vblank_start_o  output  1  one-tick pulse at the first tick of line V_VISIBLE
- frame_start_o  output  1  one-tick pulse at h=0, v=0
- frame_count_o  output  8  frame counter, wraps 255→0

Behaviour:
- Internal state:
  - h_count, 9 bits, 0..H_TOTAL-1.
  - v_count, 10 bits, 0..V_TOTAL-1 (screen lines).
  - rep, clog2(LINE_REPEAT) bits.
  - y_row, 9 bits, current game row.
- Reset (rst low, async):
  - All counters 0.
  - Outputs: current_x_o=0, current_y_o=0, next_x_o=1, next_y_o=1, hsync_o=1, vsync_o=1, visible_o=1, vblank_o=0, vblank_start_o=0, frame_start_o=0, frame_count_o=0.
  - Reset release mid-line restarts at (0,0) with no partial pulses.
- On each gpu_clk rising edge with enable_i=1:
  - h_count increments. At H_TOTAL-1 it wraps to 0 and v_count advances.
  - On v_count advance:
    - rep increments.
    - When rep reaches LINE_REPEAT-1 it wraps to 0 and y_row increments.
    - At v_count=V_TOTAL-1, v_count, rep and y_row all wrap to 0 and frame_count_o increments.
- Row count: V_TOTAL odd gives a short final row. For 525/2 the final row 262 lasts 1 screen line. Max current_y_o = ceil(V_TOTAL/LINE_REPEAT)-1 = 262.
- Output timing:
  - All outputs are registered and describe the position held in the counters. Zero combinational paths from inputs to outputs.
  - current_x_o = h_count.
  - next_x_o = (h_count==H_TOTAL-1) ? 0 : h_count+1.
- next_y_o = (y_row==262 final row) ? 0 : y_row+1; it is constant across all LINE_REPEAT screen lines of a row.
- hsync_o = 0 iff H_VISIBLE+H_FRONT ≤ h_count < H_VISIBLE+H_FRONT+H_SYNC, i.e. h_count 288..335 at defaults.
- vsync_o = 0 iff V_VISIBLE+V_FRONT ≤ v_count < V_VISIBLE+V_FRONT+V_SYNC, i.e. lines 490..491. vsync_o changes only on the h_count wrap.
- Strobe pulses:
  - vblank_start_o: exactly one tick per frame.
  - frame_start_o: coincides with the tick where h_count=0 and v_count=0.
  - Neither pulse repeats while enable_i is held low.
- enable_i=0 holds every counter and output unchanged, and pulses are forced low during the stall. Resuming continues from the held position.
- Elaboration:
  - LINE_REPEAT<2 raises $error.
  - H_TOTAL>512 or LINE_REPEAT>V_TOTAL raises $error.

Test Plan:
- Reset asserted mid-frame at h=150, v=300, then released → next cycle current_x_o=0, current_y_o=0, hsync_o=1, vsync_o=1, frame_count_o unchanged=0 after power-on reset.
- Free-run one line → hsync_o low for exactly 48 ticks starting at current_x_o=288; next_x_o=0 when current_x_o=399; visible_o high for 256 ticks.
- Free-run one frame:
  - current_y_o holds each value for 800 ticks (2 lines) for rows 0..261; row 262 holds 400 ticks.
  - next_y_o=0 during row 262.
  - vsync_o low for 800 ticks starting at line 490.
  - Frame length 210000 ticks.
- Frame boundary → vblank_start_o single pulse at v_count=480, h=0; frame_start_o single pulse at wrap; frame_count_o 255→0 after 256 frames.
- enable_i low for 37 ticks at h=287 → outputs frozen, hsync_o stays 1, no pulses; after resume hsync_o falls one tick later at current_x_o=288.
- Instantiate with LINE_REPEAT=3 → current_y_o max 174 (ceil(525/3)-1), each row 1200 ticks; LINE_REPEAT=1 fails elaboration.
